// File: rtl/msg_beat_pkg.sv
// msg_beat_pkg
// Shared definitions for the message-beat multiplexer:
//   state_t  - arbiter FSM states (IDLE waits for a header, BURST forwards payload)
//   LEN_W    - width of the payload-count field in a header beat
//   LEN_LSB  - bit position of that field inside the header beat
//   hdr_len  - extracts the payload beat count from the low header bits
package msg_beat_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int LEN_W   = 8;
  localparam int LEN_LSB = 0;

  // Callers pass only the low LEN_LSB+LEN_W bits of the header beat.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [LEN_LSB+LEN_W-1:0] hdr);
    return hdr[LEN_LSB +: LEN_W];
  endfunction

endpackage

// File: rtl/msg_beat_fifo.sv
// msg_beat_fifo
// Per-channel beat FIFO with first-word-fall-through read data.
// Parameters:
//   DEPTH   - number of beats (power of two, >= 2)
//   BEAT_W  - beat width in bits
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (empties the FIFO)
//   push        - write push_data this cycle (ignored while full, even if
//                 a pop happens in the same cycle)
//   push_data   - beat to write
//   pop         - discard the head beat (ignored while empty)
//   pop_data    - head beat, valid whenever empty is low
//   full, empty - occupancy flags decoded from the registered count
module msg_beat_fifo #(
  parameter int DEPTH  = 4,
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BEAT_W-1:0] push_data,
  input  logic              pop,
  output logic [BEAT_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BEAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/msg_beat_mux.sv
// msg_beat_mux
// Collects framed messages from NUM_CHAN beat streams, buffers each in a
// msg_beat_fifo, and forwards whole messages (never interleaved) onto a
// single registered output stream tagged with the source channel.
// A message is a header beat whose bits [7:0] give the payload count P,
// followed by P payload beats.
//
// Handshake: on every link a beat transfers at a posedge where src_rdy and
// dst_rdy are both high; a source holds its beat stable until that happens.
//
// Parameters: NUM_CHAN (2..16), BEAT_W (>= 16), DEPTH (power of two, >= 2);
//             CHAN_W = $clog2(NUM_CHAN) is derived.
// Ports:
//   CLK, RST_N   - clock, synchronous active-low reset
//   in_src_rdy   - per-channel beat valid
//   in_beat      - per-channel beats, channel i at [i*BEAT_W +: BEAT_W]
//   in_dst_rdy   - per-channel ready (FIFO not full)
//   out_src_rdy  - output beat valid (registered)
//   out_dst_rdy  - downstream ready
//   out_beat     - output beat (registered)
//   out_chan     - source channel of out_beat (registered)
//   out_last     - final beat of the current message (registered)
//   msg_count    - per-channel 16-bit completed-message counts, channel i at
//                  [i*16 +: 16]; present only with MSG_BEAT_MUX_STATS_EN
// Build option: define MSG_BEAT_MUX_STATS_EN to add the message counters.
module msg_beat_mux
  import msg_beat_pkg::*;
#(
  parameter  int NUM_CHAN = 4,
  parameter  int BEAT_W   = 32,
  parameter  int DEPTH    = 4,
  localparam int CHAN_W   = $clog2(NUM_CHAN)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_CHAN-1:0]        in_src_rdy,
  input  logic [NUM_CHAN*BEAT_W-1:0] in_beat,
  output logic [NUM_CHAN-1:0]        in_dst_rdy,
  output logic                       out_src_rdy,
  input  logic                       out_dst_rdy,
  output logic [BEAT_W-1:0]          out_beat,
  output logic [CHAN_W-1:0]          out_chan,
  output logic                       out_last
`ifdef MSG_BEAT_MUX_STATS_EN
  ,
  output logic [NUM_CHAN*16-1:0]     msg_count
`endif
);

  // ---------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------
  logic [NUM_CHAN-1:0] fifo_full;
  logic [NUM_CHAN-1:0] fifo_empty;
  logic [NUM_CHAN-1:0] fifo_push;
  logic [NUM_CHAN-1:0] fifo_pop;
  logic [BEAT_W-1:0]   fifo_data [NUM_CHAN];

  assign in_dst_rdy = ~fifo_full;
  assign fifo_push  = in_src_rdy & ~fifo_full;

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_fifo
    msg_beat_fifo #(
      .DEPTH  (DEPTH),
      .BEAT_W (BEAT_W)
    ) u_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (fifo_push[i]),
      .push_data (in_beat[i*BEAT_W +: BEAT_W]),
      .pop       (fifo_pop[i]),
      .pop_data  (fifo_data[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );
  end

  // ---------------------------------------------------------------------
  // Arbiter / FSM state
  // ---------------------------------------------------------------------
  state_t             state;
  state_t             state_nxt;
  logic [CHAN_W-1:0]  grant;
  logic [CHAN_W-1:0]  grant_nxt;
  logic [CHAN_W-1:0]  rr_ptr;
  logic [CHAN_W-1:0]  rr_nxt;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   remaining_nxt;
  logic [LEN_W-1:0]   hdr_cnt;

  logic               arb_found;
  logic [CHAN_W-1:0]  arb_sel;

  logic               out_free;
  logic               load;
  logic [BEAT_W-1:0]  load_beat;
  logic [CHAN_W-1:0]  load_chan;
  logic               load_last;

  // Increment modulo NUM_CHAN; NUM_CHAN need not be a power of two.
  function automatic logic [CHAN_W-1:0] next_chan(input logic [CHAN_W-1:0] c);
    return (c == CHAN_W'(NUM_CHAN - 1)) ? '0 : c + 1'b1;
  endfunction

  // The output register can take a new beat when it is empty or when its
  // current beat leaves this cycle, giving one beat per cycle sustained.
  assign out_free = !out_src_rdy || out_dst_rdy;

  // Round-robin search: first non-empty channel at or above rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = rr_ptr;
    for (int k = 0; k < NUM_CHAN; k++) begin
      if (!arb_found && !fifo_empty[(int'(rr_ptr) + k) % NUM_CHAN]) begin
        arb_found = 1'b1;
        arb_sel   = CHAN_W'((int'(rr_ptr) + k) % NUM_CHAN);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    remaining_nxt = remaining;
    rr_nxt        = rr_ptr;
    fifo_pop      = '0;
    load          = 1'b0;
    load_beat     = '0;
    load_chan     = '0;
    load_last     = 1'b0;
    hdr_cnt       = hdr_len(fifo_data[arb_sel][LEN_LSB+LEN_W-1:0]);

    case (state)
      IDLE: begin
        if (arb_found && out_free) begin
          fifo_pop[arb_sel] = 1'b1;
          load              = 1'b1;
          load_beat         = fifo_data[arb_sel];
          load_chan         = arb_sel;
          grant_nxt         = arb_sel;
          remaining_nxt     = hdr_cnt;
          if (hdr_cnt == '0) begin
            // Header-only message: it is its own last beat.
            load_last = 1'b1;
            rr_nxt    = next_chan(arb_sel);
          end else begin
            state_nxt = BURST;
          end
        end
      end
      BURST: begin
        // Only the granted channel is served; if its FIFO runs dry the
        // output drains and we wait here, holding the grant.
        if (!fifo_empty[grant] && out_free) begin
          fifo_pop[grant] = 1'b1;
          load            = 1'b1;
          load_beat       = fifo_data[grant];
          load_chan       = grant;
          remaining_nxt   = remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            load_last = 1'b1;
            state_nxt = IDLE;
            rr_nxt    = next_chan(grant);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_nxt;
      remaining <= remaining_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_src_rdy <= 1'b0;
      out_beat    <= '0;
      out_chan    <= '0;
      out_last    <= 1'b0;
    end else if (load) begin
      out_src_rdy <= 1'b1;
      out_beat    <= load_beat;
      out_chan    <= load_chan;
      out_last    <= load_last;
    end else if (out_dst_rdy) begin
      // Beat consumed with nothing to replace it; data fields keep their
      // last value, only the valid flag drops.
      out_src_rdy <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Completed-message statistics
  // ---------------------------------------------------------------------
`ifdef MSG_BEAT_MUX_STATS_EN
  logic [15:0] msg_cnt [NUM_CHAN];

  // A message completes when its last beat leaves the output register;
  // counters wrap from 0xFFFF to 0.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        msg_cnt[i] <= '0;
      end
    end else if (out_src_rdy && out_dst_rdy && out_last) begin
      msg_cnt[out_chan] <= msg_cnt[out_chan] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_stats
    assign msg_count[i*16 +: 16] = msg_cnt[i];
  end
`else
  // Statistics build option disabled: no counters and no msg_count port.
`endif

endmodule

// File: tb/tb_msg_beat_mux.sv
// tb_msg_beat_mux
// Self-checking bench for msg_beat_mux (NUM_CHAN=4, BEAT_W=32, DEPTH=4).
// Table-driven single-channel and zero-length vectors, followed by
// contention, backpressure and mid-burst reset sequences.
module tb_msg_beat_mux;
  import msg_beat_pkg::*;

  localparam int NUM_CHAN = 4;
  localparam int BEAT_W   = 32;
  localparam int DEPTH    = 4;
  localparam int CHAN_W   = 2;
  localparam int EXP_W    = CHAN_W + 1 + BEAT_W;

  // ---------------- clock / reset / DUT ----------------
  logic                       CLK = 1'b0;
  logic                       RST_N;
  logic [NUM_CHAN-1:0]        in_src_rdy;
  logic [NUM_CHAN*BEAT_W-1:0] in_beat;
  logic [NUM_CHAN-1:0]        in_dst_rdy;
  logic                       out_src_rdy;
  logic                       out_dst_rdy;
  logic [BEAT_W-1:0]          out_beat;
  logic [CHAN_W-1:0]          out_chan;
  logic                       out_last;
`ifdef MSG_BEAT_MUX_STATS_EN
  logic [NUM_CHAN*16-1:0]     msg_count;
`endif

  always #5 CLK = ~CLK;

  msg_beat_mux #(
    .NUM_CHAN (NUM_CHAN),
    .BEAT_W   (BEAT_W),
    .DEPTH    (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_src_rdy  (in_src_rdy),
    .in_beat     (in_beat),
    .in_dst_rdy  (in_dst_rdy),
    .out_src_rdy (out_src_rdy),
    .out_dst_rdy (out_dst_rdy),
    .out_beat    (out_beat),
    .out_chan    (out_chan),
    .out_last    (out_last)
`ifdef MSG_BEAT_MUX_STATS_EN
    ,
    .msg_count   (msg_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit mon_en  = 1'b0;
  bit gap_chk = 1'b0;
  bit seen    = 1'b0;

  function automatic logic [EXP_W-1:0] mk(input int ch, input bit last, input logic [BEAT_W-1:0] b);
    return {CHAN_W'(ch), last, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called just before the active edge, when this cycle's handshake is decided.
  task automatic monitor();
    logic [EXP_W-1:0] e;
    if (out_src_rdy && out_dst_rdy) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL extra_beat: got chan %0d beat %0h expected no beat", out_chan, out_beat);
      end else begin
        e = exp_q.pop_front();
        chk("out_seq", {out_chan, out_last, out_beat}, e);
        seen = 1'b1;
      end
    end else if (gap_chk && seen && out_dst_rdy && exp_q.size() > 0) begin
      n_total++;
      $display("FAIL bubble: got idle output expected beat %0h", exp_q[0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge CLK);
    if (mon_en) monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_beat(input int ch, input logic [BEAT_W-1:0] b);
    in_beat[ch*BEAT_W +: BEAT_W] = b;
  endtask

  task automatic do_reset();
    RST_N       = 1'b0;
    in_src_rdy  = '0;
    in_beat     = '0;
    out_dst_rdy = 1'b1;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NUM_CHAN-1:0]        src;
    logic [NUM_CHAN*BEAT_W-1:0] beats;
    logic                       e_vld;
    logic [BEAT_W-1:0]          e_beat;
    logic [CHAN_W-1:0]          e_chan;
    logic                       e_last;
    logic [NUM_CHAN-1:0]        e_irdy;
  } vec_t;

  vec_t vecs [8];

  logic [BEAT_W-1:0] bp [13];
  logic [BEAT_W-1:0] hd;
  int   sent;
  logic acc;

  initial begin
    // Channel 0: header P=2, payload A, B; then channel 2 zero-length message.
    vecs[0] = '{4'b0001, {96'h0, 32'h0001_0002}, 1'b0, 32'h0,          2'd0, 1'b0, 4'hF};
    vecs[1] = '{4'b0001, {96'h0, 32'h0000_000A}, 1'b1, 32'h0001_0002,  2'd0, 1'b0, 4'hF};
    vecs[2] = '{4'b0001, {96'h0, 32'h0000_000B}, 1'b1, 32'h0000_000A,  2'd0, 1'b0, 4'hF};
    vecs[3] = '{4'b0000, 128'h0,                 1'b1, 32'h0000_000B,  2'd0, 1'b1, 4'hF};
    vecs[4] = '{4'b0000, 128'h0,                 1'b0, 32'h0,          2'd0, 1'b0, 4'hF};
    vecs[5] = '{4'b0100, 128'h0,                 1'b0, 32'h0,          2'd0, 1'b0, 4'hF};
    vecs[6] = '{4'b0000, 128'h0,                 1'b1, 32'h0000_0000,  2'd2, 1'b1, 4'hF};
    vecs[7] = '{4'b0000, 128'h0,                 1'b0, 32'h0,          2'd0, 1'b0, 4'hF};

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_out_src_rdy", 64'(out_src_rdy), 64'd0);
    chk("rst_out_beat",    64'(out_beat),    64'd0);
    chk("rst_out_chan",    64'(out_chan),    64'd0);
    chk("rst_out_last",    64'(out_last),    64'd0);
    chk("rst_in_dst_rdy",  64'(in_dst_rdy),  64'hF);
    chk("rst_rr_ptr",      64'(dut.rr_ptr),  64'd0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 8; i++) begin
      in_src_rdy = vecs[i].src;
      in_beat    = vecs[i].beats;
      step();
      chk($sformatf("v%0d_out_src_rdy", i), 64'(out_src_rdy), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_in_dst_rdy", i),  64'(in_dst_rdy),  64'(vecs[i].e_irdy));
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d_out_beat", i), 64'(out_beat), 64'(vecs[i].e_beat));
        chk($sformatf("v%0d_out_chan", i), 64'(out_chan), 64'(vecs[i].e_chan));
        chk($sformatf("v%0d_out_last", i), 64'(out_last), 64'(vecs[i].e_last));
      end
      if (i == 6) begin
        chk("zero_len_state", 64'(dut.state),  64'(IDLE));
        chk("zero_len_rr",    64'(dut.rr_ptr), 64'd3);
      end
    end

    // ---------------- contention: channels 0, 1, 3 ----------------
    do_reset();
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (c != 2) begin
        exp_q.push_back(mk(c, 1'b0, 32'h1000_0002 | (c << 16)));
        exp_q.push_back(mk(c, 1'b0, 32'hA000_0000 | c));
        exp_q.push_back(mk(c, 1'b1, 32'hB000_0000 | c));
      end
    end
    mon_en  = 1'b1;
    gap_chk = 1'b1;
    seen    = 1'b0;
    in_src_rdy = 4'b1011;
    for (int c = 0; c < NUM_CHAN; c++) set_beat(c, 32'h1000_0002 | (c << 16));
    step();
    for (int c = 0; c < NUM_CHAN; c++) set_beat(c, 32'hA000_0000 | c);
    step();
    for (int c = 0; c < NUM_CHAN; c++) set_beat(c, 32'hB000_0000 | c);
    step();
    in_src_rdy = '0;
    drain("contention_done", 30);
    gap_chk = 1'b0;
    chk("contention_rr", 64'(dut.rr_ptr), 64'd0);

    // ---------------- backpressure on channel 1 ----------------
    bp[0] = 32'h3000_000C;
    for (int k = 1; k < 13; k++) bp[k] = 32'h4000_0000 + k;
    for (int k = 0; k < 13; k++) exp_q.push_back(mk(1, k == 12, bp[k]));
    out_dst_rdy = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_src_rdy[1] = (sent < 13);
      set_beat(1, bp[sent < 13 ? sent : 12]);
      acc = in_src_rdy[1] && in_dst_rdy[1];
      step();
      if (acc) sent++;
      if (cyc >= 2) begin
        chk("bp_hold_vld",  64'(out_src_rdy), 64'd1);
        chk("bp_hold_beat", 64'(out_beat),    64'(bp[0]));
        chk("bp_hold_chan", 64'(out_chan),    64'd1);
      end
    end
    chk("bp_accepted",   64'(sent),          64'(DEPTH + 1));
    chk("bp_in_dst_rdy", 64'(in_dst_rdy[1]), 64'd0);
    out_dst_rdy = 1'b1;
    for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
      in_src_rdy[1] = (sent < 13);
      set_beat(1, bp[sent < 13 ? sent : 12]);
      acc = in_src_rdy[1] && in_dst_rdy[1];
      step();
      if (acc) sent++;
    end
    in_src_rdy = '0;
    chk("bp_done",  64'(exp_q.size()), 64'd0);
    chk("bp_sent",  64'(sent),         64'd13);
    exp_q.delete();

    // ---------------- reset in the middle of a burst ----------------
    mon_en = 1'b0;
    in_src_rdy = 4'b0001;
    set_beat(0, 32'h5000_0004);
    step();
    for (int k = 1; k <= 3; k++) begin
      set_beat(0, 32'h6000_0000 + k);
      step();
    end
    chk("mid_burst_beat",  64'(out_beat),  64'h6000_0002);
    chk("mid_burst_state", 64'(dut.state), 64'(BURST));
    RST_N      = 1'b0;
    in_src_rdy = '0;
    step();
    RST_N = 1'b1;
    chk("mrst_out_src_rdy", 64'(out_src_rdy),   64'd0);
    chk("mrst_out_beat",    64'(out_beat),      64'd0);
    chk("mrst_out_chan",    64'(out_chan),      64'd0);
    chk("mrst_out_last",    64'(out_last),      64'd0);
    chk("mrst_in_dst_rdy",  64'(in_dst_rdy),    64'hF);
    chk("mrst_state",       64'(dut.state),     64'(IDLE));
    chk("mrst_rr",          64'(dut.rr_ptr),    64'd0);
    chk("mrst_remaining",   64'(dut.remaining), 64'd0);

    // New message after reset: only its two beats may appear.
    hd = 32'h7000_0001;
    exp_q.push_back(mk(3, 1'b0, hd));
    exp_q.push_back(mk(3, 1'b1, 32'h7000_00EE));
    mon_en = 1'b1;
    in_src_rdy = 4'b1000;
    set_beat(3, hd);
    step();
    set_beat(3, 32'h7000_00EE);
    step();
    in_src_rdy = '0;
    drain("post_reset_done", 20);
    repeat (5) step();
    mon_en = 1'b0;

`ifdef MSG_BEAT_MUX_STATS_EN
    // ---------------- statistics ----------------
    do_reset();
    in_src_rdy = 4'b0001;
    set_beat(0, 32'h0);
    repeat (3) step();
    in_src_rdy = '0;
    repeat (6) step();
    chk("stats_count_ch0", 64'(msg_count[15:0]),  64'd3);
    chk("stats_count_ch1", 64'(msg_count[31:16]), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/msg_beat_mux.md
# msg_beat_mux

Multi-channel message-beat arbiter for the simulation top level. It collects framed messages from NUM_CHAN independent src_rdy/dst_rdy beat streams, buffers each stream in a small per-channel FIFO, and forwards whole messages, never interleaved, onto one output beat stream tagged with the channel number. It sits between the portal message sources and the single DPI-facing msgSource beat interface, so many portals share one host link.

## Interface
- NUM_CHAN, 4, number of input channels (2..16)
- BEAT_W, 32, beat width in bits (>= 16)
- DEPTH, 4, per-channel FIFO depth in beats (power of two, >= 2)
- CHAN_W, $clog2(NUM_CHAN), derived channel-id width; not overridable
- CLK  in  1  single clock; all state updates on posedge
- RST_N  in  1  reset, synchronous, active-low
- in_src_rdy  in  NUM_CHAN  per-channel beat valid
- in_beat  in  NUM_CHAN*BEAT_W  per-channel beat; channel i occupies bits [i*BEAT_W +: BEAT_W]
- in_dst_rdy  out  NUM_CHAN  per-channel ready; equals !fifo_full[i]
- out_src_rdy  out  1  output beat valid (registered)
- out_dst_rdy  in  1  downstream ready
- out_beat  out  BEAT_W  output beat (registered)
- out_chan  out  CHAN_W  source channel of out_beat (registered)
- out_last  out  1  final beat of current message (registered)

## Operation
- Transfer on any link occurs when src_rdy && dst_rdy are both high at a posedge.
- Framing: the first beat of a message is the header. Header bits [7:0] give the payload beat count P (0..255) that follows. A message is P+1 beats.
- Per-channel FIFO: write on input handshake. in_dst_rdy[i] = !full[i]. When full, no write is accepted even if a pop happens in the same cycle.
- FSM states:
  - IDLE: the round-robin arbiter picks the first non-empty channel, searching from rr_ptr upward with wrap. It pops that channel's header into the output stage, latches grant and remaining = P, and goes to BURST if P != 0. If P == 0 it stays in IDLE and sets out_last.
  - BURST: pops only the granted channel; each pop decrements remaining. The pop with remaining == 1 sets out_last and returns the FSM to IDLE.
- rr_ptr advances to (grant+1) mod NUM_CHAN when the last beat of a message is loaded into the output stage.
- Output stage is a single register. It loads when it is empty or when it is being consumed that cycle (out_src_rdy && out_dst_rdy). This gives full throughput of 1 beat/cycle.
- In BURST with the granted FIFO empty: the output stage drains, and out_src_rdy drops after the handshake. The FSM holds grant; other channels are not served.
- Reset values: out_src_rdy=0, out_beat=0, out_chan=0, out_last=0, all FIFOs empty (in_dst_rdy all 1 from the first cycle after reset), FSM=IDLE, rr_ptr=0, remaining=0.
- Reset mid-message discards all buffered and partially forwarded beats. No recovery framing is attempted.

## Timing
- Input handshake at edge t into an empty FIFO, FSM in IDLE, output stage empty: out_src_rdy is high in the cycle after edge t+1 (2-cycle latency).
- Sustained message: one beat per cycle while the FIFO is non-empty and out_dst_rdy=1.
- Between messages: no bubble. The next header may load on the same edge that the previous last beat is consumed.
- out_* holds stable while out_src_rdy=1 && out_dst_rdy=0.

## Configuration
- MSG_BEAT_MUX_STATS_EN defined:
  - adds output port msg_count (NUM_CHAN*16 bits, out);
  - per-channel 16-bit count of completed messages, incremented when a last beat is consumed at the output;
  - counts wrap 0xFFFF->0 and reset to 0.
- Undefined: the port and the counters are absent. All other behaviour is identical.

## Structure
- Package msg_beat_pkg holds:
  - state enum {IDLE, BURST};
  - LEN_W=8 and LEN_LSB=0;
  - function hdr_len(beat) returning the payload count.
- Sub-module msg_beat_fifo(DEPTH, BEAT_W) provides the per-channel FIFO: registered count, full/empty flags, pointers wrapping mod DEPTH. It is instantiated NUM_CHAN times.
- The arbiter, FSM and output register live in the top module.

## Test plan
- Single channel: channel 0 sends header 0x00010002 then payload 0xA, 0xB. The output shows the 3 beats in order with out_chan=0, out_last only on 0xB, and the first valid 2 cycles after the header handshake.
- Zero-length message: channel 2 sends header 0x00000000. The output shows one beat with out_last=1 and out_chan=2; the FSM returns to IDLE and rr_ptr=3.
- Contention: channels 0, 1 and 3 each hold a 2-payload message at once, with rr_ptr=0. Output order is 0, 1, 3; no interleaving; no idle cycles with out_dst_rdy=1.
- Backpressure: out_dst_rdy=0 for 10 cycles while channel 1 streams. in_dst_rdy[1] falls after DEPTH+1 accepted beats, and out_* stays stable. On release, beats arrive in order with none lost.
- Reset mid-BURST: RST_N=0 for 1 cycle after 2 of 5 beats. The next cycle shows all outputs at reset values and in_dst_rdy all 1. A new message then completes normally.
- Under MSG_BEAT_MUX_STATS_EN: channel 0 sends 3 messages, then msg_count[15:0]=3. Preloading the counter to 0xFFFF, one more message gives 0.
